reg_access_ctrl: RTL and testbench

- Sequencer on the requester side of the register stack port. It is the only block that drives the stack's num1/num2/setnum/setval/get_enable/set_enable, and it consumes the stack's out1/out2.
- Upstream it offers two interfaces: a valid/ready operand-fetch channel (two register numbers in, two operand words out) and a buffered writeback channel.
- It serialises stack accesses, never asserts get and set together, and enforces read-after-write ordering against queued writebacks.

---
 rtl/reg_access_ctrl_if.sv | 41 ++++
 rtl/reg_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_reg_access_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_ctrl_if.sv
// Bundle of the upstream fetch/writeback channels and the register-stack port
// seen by reg_access_ctrl.
interface reg_access_ctrl_if #(
  parameter int NIB_SIZE  = 4,
  parameter int WORD_SIZE = 16
);
  logic                 rd_valid;
  logic                 rd_ready;
  logic [NIB_SIZE-1:0]  rd_num1;
  logic [NIB_SIZE-1:0]  rd_num2;
  logic                 op_valid;
  logic                 op_ready;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [NIB_SIZE-1:0]  wb_num;
  logic [WORD_SIZE-1:0] wb_val;
  logic [NIB_SIZE-1:0]  rs_num1;
  logic [NIB_SIZE-1:0]  rs_num2;
  logic [NIB_SIZE-1:0]  rs_setnum;
  logic [WORD_SIZE-1:0] rs_setval;
  logic                 rs_get_enable;
  logic                 rs_set_enable;
  logic [WORD_SIZE-1:0] rs_out1;
  logic [WORD_SIZE-1:0] rs_out2;

  modport slave (
    input  rd_valid, rd_num1, rd_num2, op_ready, wb_valid, wb_num, wb_val,
           rs_out1, rs_out2,
    output rd_ready, op_valid, op_a, op_b, wb_ready,
           rs_num1, rs_num2, rs_setnum, rs_setval, rs_get_enable, rs_set_enable
  );

  modport master (
    output rd_valid, rd_num1, rd_num2, op_ready, wb_valid, wb_num, wb_val,
           rs_out1, rs_out2,
    input  rd_ready, op_valid, op_a, op_b, wb_ready,
           rs_num1, rs_num2, rs_setnum, rs_setval, rs_get_enable, rs_set_enable
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Requester-side sequencer for the register stack: serialises operand fetches
// and queued writebacks, holding back reads that hit a pending write.
module reg_access_ctrl #(
  parameter int NIB_SIZE  = 4,
  parameter int WORD_SIZE = 16,
  parameter int WB_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  reg_access_ctrl_if.slave  bus,
  output logic              busy
);
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, GET, CAP, PRES, SET} state_t;

  state_t               state_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [NIB_SIZE-1:0]  q_num [WB_DEPTH];
  logic [WORD_SIZE-1:0] q_val [WB_DEPTH];

  logic [NIB_SIZE-1:0]  rs_num1_reg;
  logic [NIB_SIZE-1:0]  rs_num2_reg;
  logic [NIB_SIZE-1:0]  rs_setnum_reg;
  logic [WORD_SIZE-1:0] rs_setval_reg;
  logic                 rs_get_enable_reg;
  logic                 rs_set_enable_reg;
  logic                 op_valid_reg;
  logic [WORD_SIZE-1:0] op_a_reg;
  logic [WORD_SIZE-1:0] op_b_reg;

  logic                 full;
  logic                 empty;
  logic                 hazard;
  logic                 start_read;
  logic                 push;
  logic                 pop;
  logic [WB_DEPTH-1:0]  entry_hit;

  assign full  = (count_reg == CNT_W'(WB_DEPTH));
  assign empty = (count_reg == '0);

  // An entry is live when its distance from the head is below the fill count.
  for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_hazard
    logic [PTR_W-1:0] offset;
    assign offset        = PTR_W'(gi) - rd_ptr_reg;
    assign entry_hit[gi] = (CNT_W'(offset) < count_reg) &&
                           ((q_num[gi] == bus.rd_num1) || (q_num[gi] == bus.rd_num2));
  end

  assign hazard     = |entry_hit;
  assign start_read = (state_reg == IDLE) && bus.rd_valid && !hazard;
  assign pop        = (state_reg == IDLE) && !start_read && !empty;
  assign push       = bus.wb_valid && !full;

  assign bus.rd_ready = reset_n && (state_reg == IDLE) && !hazard;
  assign bus.wb_ready = !full;
  assign busy         = (state_reg != IDLE) || !empty;

  assign bus.rs_num1       = rs_num1_reg;
  assign bus.rs_num2       = rs_num2_reg;
  assign bus.rs_setnum     = rs_setnum_reg;
  assign bus.rs_setval     = rs_setval_reg;
  assign bus.rs_get_enable = rs_get_enable_reg;
  assign bus.rs_set_enable = rs_set_enable_reg;
  assign bus.op_valid      = op_valid_reg;
  assign bus.op_a          = op_a_reg;
  assign bus.op_b          = op_b_reg;

  // Queue storage carries no reset; liveness is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_num[wr_ptr_reg] <= bus.wb_num;
      q_val[wr_ptr_reg] <= bus.wb_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      rs_num1_reg       <= '0;
      rs_num2_reg       <= '0;
      rs_setnum_reg     <= '0;
      rs_setval_reg     <= '0;
      rs_get_enable_reg <= 1'b0;
      rs_set_enable_reg <= 1'b0;
      op_valid_reg      <= 1'b0;
      op_a_reg          <= '0;
      op_b_reg          <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (start_read) begin
            rs_num1_reg       <= bus.rd_num1;
            rs_num2_reg       <= bus.rd_num2;
            rs_get_enable_reg <= 1'b1;
            state_reg         <= GET;
          end else if (pop) begin
            rs_setnum_reg     <= q_num[rd_ptr_reg];
            rs_setval_reg     <= q_val[rd_ptr_reg];
            rs_set_enable_reg <= 1'b1;
            state_reg         <= SET;
          end
        end
        GET: begin
          rs_get_enable_reg <= 1'b0;
          state_reg         <= CAP;
        end
        // The stack registered its outputs at the end of GET.
        CAP: begin
          op_a_reg     <= bus.rs_out1;
          op_b_reg     <= bus.rs_out2;
          op_valid_reg <= 1'b1;
          state_reg    <= PRES;
        end
        PRES: begin
          if (bus.op_ready) begin
            op_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        SET: begin
          rs_set_enable_reg <= 1'b0;
          state_reg         <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register stack and a
// scoreboard of expected operand pairs.
module tb_reg_access_ctrl;
  localparam int NIB  = 4;
  localparam int WORD = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic stk_init;

  reg_access_ctrl_if #(.NIB_SIZE(NIB), .WORD_SIZE(WORD)) bus ();

  reg_access_ctrl #(.NIB_SIZE(NIB), .WORD_SIZE(WORD), .WB_DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural stack: registered outputs, write on set_enable.
  logic [WORD-1:0] stk [16];
  int              get_cnt;
  int              set_cnt;
  logic            both_seen;
  logic [NIB-1:0]  set_log [64];

  always_ff @(posedge clk) begin
    if (stk_init) begin
      for (int i = 0; i < 16; i++) stk[i] <= WORD'(i);
      bus.rs_out1 <= '0;
      bus.rs_out2 <= '0;
      get_cnt     <= 0;
      set_cnt     <= 0;
      both_seen   <= 1'b0;
    end else begin
      if (bus.rs_get_enable && bus.rs_set_enable) both_seen <= 1'b1;
      if (bus.rs_set_enable) begin
        stk[bus.rs_setnum]      <= bus.rs_setval;
        set_log[set_cnt[5:0]]   <= bus.rs_setnum;
        set_cnt                 <= set_cnt + 1;
      end
      if (bus.rs_get_enable) begin
        bus.rs_out1 <= stk[bus.rs_num1];
        bus.rs_out2 <= stk[bus.rs_num2];
        get_cnt     <= get_cnt + 1;
      end
    end
  end

  int              vectors = 0;
  int              miscompares = 0;
  logic [WORD-1:0] model [16];
  logic [31:0]     exp_q [$];
  logic            rd_acc;
  logic            wb_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: resolve handshakes for the coming edge, then advance.
  task automatic tick();
    #1;
    rd_acc = bus.rd_valid && bus.rd_ready;
    wb_acc = bus.wb_valid && bus.wb_ready;
    if (rd_acc) exp_q.push_back({model[bus.rd_num1], model[bus.rd_num2]});
    if (wb_acc) model[bus.wb_num] = bus.wb_val;
    @(negedge clk);
    if (rd_acc) bus.rd_valid = 1'b0;
    if (wb_acc) bus.wb_valid = 1'b0;
  endtask

  task automatic wait_op(input string tag, input int bound);
    int n = 0;
    logic [31:0] e;
    while (!bus.op_valid && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_op_valid"}, 32'(bus.op_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_op_a"}, 32'(bus.op_a), 32'(e[31:16]));
    chk({tag, "_op_b"}, 32'(bus.op_b), 32'(e[15:0]));
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic fetch(input string tag, input logic [NIB-1:0] n1, input logic [NIB-1:0] n2);
    int n = 0;
    bus.rd_valid = 1'b1;
    bus.rd_num1  = n1;
    bus.rd_num2  = n2;
    bus.op_ready = 1'b1;
    while (bus.rd_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_accepted"}, 32'(bus.rd_valid), 32'd0);
    wait_op(tag, 4);
    wait_idle(tag, 10);
  endtask

  // Fetch (3,5) from an otherwise idle block, checking exact cycle timing.
  task automatic fetch_strict(input string tag);
    int g0;
    g0 = get_cnt;
    bus.rd_valid = 1'b1;
    bus.rd_num1  = 4'd3;
    bus.rd_num2  = 4'd5;
    bus.op_ready = 1'b1;
    #1;
    chk({tag, "_rd_ready"}, 32'(bus.rd_ready), 32'd1);
    tick();
    chk({tag, "_get_on"}, 32'(bus.rs_get_enable), 32'd1);
    chk({tag, "_rs_num1"}, 32'(bus.rs_num1), 32'd3);
    tick();
    chk({tag, "_get_off"}, 32'(bus.rs_get_enable), 32'd0);
    chk({tag, "_op_early"}, 32'(bus.op_valid), 32'd0);
    tick();
    wait_op(tag, 0);
    chk({tag, "_op_a_const"}, 32'(bus.op_a), 32'h3);
    chk({tag, "_op_b_const"}, 32'(bus.op_b), 32'h5);
    tick();
    chk({tag, "_op_clr"}, 32'(bus.op_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_get_pulses"}, 32'(get_cnt - g0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g0;
    int s0;
    logic [WORD-1:0] hold_a;
    logic [WORD-1:0] hold_b;
    logic [WORD-1:0] save13;
    logic [WORD-1:0] save14;

    bus.rd_valid = 1'b0;
    bus.rd_num1  = '0;
    bus.rd_num2  = '0;
    bus.op_ready = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_num   = '0;
    bus.wb_val   = '0;
    for (int i = 0; i < 16; i++) model[i] = WORD'(i);
    stk_init = 1'b1;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_get", 32'(bus.rs_get_enable), 32'd0);
    chk("rst_set", 32'(bus.rs_set_enable), 32'd0);
    @(negedge clk);
    @(negedge clk);
    stk_init = 1'b0;
    reset_n  = 1'b1;

    // Scenario 1: plain fetch from initial contents.
    fetch_strict("s1");

    // Scenario 2: read-after-write hazard on register 7.
    bus.wb_valid = 1'b1;
    bus.wb_num   = 4'd7;
    bus.wb_val   = 16'hBEEF;
    tick();
    chk("s2_wb_pushed", 32'(bus.wb_valid), 32'd0);
    s0 = set_cnt;
    bus.rd_valid = 1'b1;
    bus.rd_num1  = 4'd7;
    bus.rd_num2  = 4'd2;
    #1;
    chk("s2_rd_hazard", 32'(bus.rd_ready), 32'd0);
    n = 0;
    while (bus.rd_valid && n < 10) begin
      tick();
      n++;
    end
    chk("s2_accept_wait", 32'(n), 32'd3);
    chk("s2_set_before_read", 32'(set_cnt - s0), 32'd1);
    wait_op("s2", 4);
    chk("s2_op_a_const", 32'(bus.op_a), 32'hBEEF);
    wait_idle("s2", 10);

    // Scenario 3/5: queue fills while a fetch is parked in PRES.
    bus.op_ready = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_num1  = 4'd8;
    bus.rd_num2  = 4'd9;
    tick();
    tick();
    tick();
    wait_op("s3_fetch", 0);
    hold_a = bus.op_a;
    hold_b = bus.op_b;
    g0 = get_cnt;
    s0 = set_cnt;
    bus.wb_valid = 1'b1; bus.wb_num = 4'd10; bus.wb_val = 16'h1111;
    tick();
    bus.wb_valid = 1'b1; bus.wb_num = 4'd11; bus.wb_val = 16'h2222;
    tick();
    #1;
    chk("s3_full", 32'(bus.wb_ready), 32'd0);
    bus.wb_valid = 1'b1; bus.wb_num = 4'd12; bus.wb_val = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_hold_valid", 32'(bus.op_valid), 32'd1);
      chk("s3_hold_a", 32'(bus.op_a), 32'(hold_a));
      chk("s3_hold_b", 32'(bus.op_b), 32'(hold_b));
    end
    chk("s3_no_get", 32'(get_cnt - g0), 32'd0);
    chk("s3_no_set", 32'(set_cnt - s0), 32'd0);
    chk("s3_third_waiting", 32'(bus.wb_valid), 32'd1);
    bus.op_ready = 1'b1;
    n = 0;
    while (bus.wb_valid && n < 10) begin
      tick();
      n++;
    end
    chk("s3_third_pushed", 32'(bus.wb_valid), 32'd0);
    wait_idle("s3", 20);
    chk("s3_set_pulses", 32'(set_cnt - s0), 32'd3);
    chk("s3_order0", 32'(set_log[s0[5:0]]), 32'd10);
    chk("s3_order1", 32'(set_log[6'(s0 + 1)]), 32'd11);
    chk("s3_order2", 32'(set_log[6'(s0 + 2)]), 32'd12);
    fetch("s3_rb01", 4'd10, 4'd11);
    fetch("s3_rb2", 4'd12, 4'd12);

    // Scenario 4: push in the same cycle as read acceptance is ordered after it.
    bus.rd_valid = 1'b1; bus.rd_num1 = 4'd1; bus.rd_num2 = 4'd4;
    bus.wb_valid = 1'b1; bus.wb_num = 4'd1; bus.wb_val = 16'h0055;
    bus.op_ready = 1'b1;
    tick();
    chk("s4_same_edge", 32'({bus.rd_valid, bus.wb_valid}), 32'd0);
    wait_op("s4", 4);
    chk("s4_old_value", 32'(bus.op_a), 32'h1);
    wait_idle("s4", 10);
    fetch("s4_new", 4'd1, 4'd1);

    // Scenario 6: reset while GET is in flight with a full queue.
    bus.op_ready = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_num1 = 4'd2; bus.rd_num2 = 4'd3;
    tick();
    tick();
    tick();
    wait_op("s6_pre", 0);
    save13 = model[13];
    save14 = model[14];
    bus.wb_valid = 1'b1; bus.wb_num = 4'd13; bus.wb_val = 16'hAAAA;
    tick();
    bus.wb_valid = 1'b1; bus.wb_num = 4'd14; bus.wb_val = 16'hBBBB;
    tick();
    bus.op_ready = 1'b1;
    tick();
    chk("s6_back_idle", 32'(bus.op_valid), 32'd0);
    bus.rd_valid = 1'b1; bus.rd_num1 = 4'd0; bus.rd_num2 = 4'd6;
    tick();
    chk("s6_in_get", 32'(bus.rs_get_enable), 32'd1);
    chk("s6_queue_full", 32'(bus.wb_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_get", 32'(bus.rs_get_enable), 32'd0);
    chk("s6_rst_num1", 32'(bus.rs_num1), 32'd0);
    chk("s6_rst_setval", 32'(bus.rs_setval), 32'd0);
    chk("s6_rst_op_a", 32'(bus.op_a), 32'd0);
    chk("s6_rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("s6_rst_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk("s6_rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    model[13] = save13;
    model[14] = save14;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    s0 = set_cnt;
    tick();
    tick();
    tick();
    chk("s6_queue_dropped", 32'(set_cnt - s0), 32'd0);
    fetch_strict("s6_after");
    fetch("s6_lost", 4'd13, 4'd14);

    chk("never_get_and_set", 32'(both_seen), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
